// File: rtl/udp_photo_tx_packetizer_if.sv
// Handshake bundle between the photo TX packetizer, its frame-buffer source
// and the UDP/RMII transmit engine.
interface udp_photo_tx_packetizer_if;
    logic        start;
    logic        src_valid;
    logic [15:0] src_data;
    logic        src_ready;
    logic        pkt_req;
    logic [15:0] pkt_len;
    logic        pkt_ack;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_last;
    logic        tx_ready;
    logic        busy;
    logic        frame_done;
    logic [7:0]  frame_id;

    modport master (
        input  start, src_valid, src_data, pkt_ack, tx_ready,
        output src_ready, pkt_req, pkt_len, tx_valid, tx_data, tx_last,
               busy, frame_done, frame_id
    );

    modport slave (
        output start, src_valid, src_data, pkt_ack, tx_ready,
        input  src_ready, pkt_req, pkt_len, tx_valid, tx_data, tx_last,
               busy, frame_done, frame_id
    );
endinterface

// File: rtl/udp_photo_tx_packetizer.sv
// Slices one stored frame into line packets (4-byte header + 16-bit words sent
// high byte first) and streams them byte-wise to the UDP/RMII TX engine.
module udp_photo_tx_packetizer #(
    parameter int unsigned PKT_WORDS  = 240,
    parameter int unsigned PKT_NUM    = 360,
    parameter int unsigned GAP_CYCLES = 16,
    parameter logic [7:0]  HDR_MAGIC  = 8'hA5
) (
    input  logic                        sys_clk,
    input  logic                        rst_n,
    udp_photo_tx_packetizer_if.master   bus
);
    typedef enum logic [2:0] {IDLE, REQ, HDR, PAY_HI, PAY_LO, GAP} state_e;

    localparam logic [15:0] WORD_LAST = 16'(PKT_WORDS - 1);
    localparam logic [15:0] LINE_LAST = 16'(PKT_NUM - 1);
    localparam logic [15:0] GAP_LAST  = (GAP_CYCLES == 0) ? 16'd0 : 16'(GAP_CYCLES - 1);

    state_e      state_q;
    logic [15:0] line_q;
    logic [15:0] word_q;
    logic [15:0] gap_q;
    logic [1:0]  hdr_q;
    logic [7:0]  lo_q;
    logic [7:0]  frame_id_q;
    logic [7:0]  tx_data_q;
    logic        tx_valid_q;
    logic        tx_last_q;
    logic        pkt_req_q;
    logic        busy_q;
    logic        frame_done_q;

    logic        slot_free;
    logic        src_take;
    logic        last_accept;
    logic        pkt_end;
    logic [7:0]  hdr_byte;

    assign slot_free   = !tx_valid_q || bus.tx_ready;
    assign src_take    = (state_q == PAY_HI) && slot_free && bus.src_valid;
    assign last_accept = (state_q == PAY_LO) && tx_valid_q && tx_last_q && bus.tx_ready;
    // With no gap configured the packet ends on the same edge its last byte leaves.
    assign pkt_end     = (GAP_CYCLES == 0) ? last_accept
                                           : ((state_q == GAP) && (gap_q == GAP_LAST));

    // NOTE: the default arm makes the case full, so hdr_byte never holds a stale value (no latch).
    always_comb begin
        case (hdr_q)
            2'd0:    hdr_byte = HDR_MAGIC;
            2'd1:    hdr_byte = frame_id_q;
            2'd2:    hdr_byte = line_q[15:8];
            default: hdr_byte = line_q[7:0];
        endcase
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            line_q       <= '0;
            word_q       <= '0;
            gap_q        <= '0;
            hdr_q        <= '0;
            lo_q         <= '0;
            frame_id_q   <= '0;
            tx_data_q    <= '0;
            tx_valid_q   <= 1'b0;
            tx_last_q    <= 1'b0;
            pkt_req_q    <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            // A free slot empties unless a state below loads a new byte into it.
            if (slot_free) begin
                tx_valid_q <= 1'b0;
                tx_last_q  <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    busy_q <= 1'b0;
                    if (bus.start && !busy_q) begin
                        busy_q    <= 1'b1;
                        pkt_req_q <= 1'b1;
                        line_q    <= '0;
                        word_q    <= '0;
                        hdr_q     <= '0;
                        state_q   <= REQ;
                    end
                end
                REQ: begin
                    if (bus.pkt_ack) begin
                        pkt_req_q <= 1'b0;
                        state_q   <= HDR;
                    end
                end
                HDR: begin
                    if (slot_free) begin
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= hdr_byte;
                        hdr_q      <= hdr_q + 2'd1;
                        if (hdr_q == 2'd3) state_q <= PAY_HI;
                    end
                end
                PAY_HI: begin
                    if (src_take) begin
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= bus.src_data[15:8];
                        lo_q       <= bus.src_data[7:0];
                        state_q    <= PAY_LO;
                    end
                end
                PAY_LO: begin
                    // tx_last_q set here means the packet's final byte is still in the slot.
                    if (tx_last_q) begin
                        if (bus.tx_ready) begin
                            gap_q   <= '0;
                            state_q <= GAP;
                        end
                    end else if (slot_free) begin
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= lo_q;
                        tx_last_q  <= (word_q == WORD_LAST);
                        word_q     <= word_q + 16'd1;
                        if (word_q != WORD_LAST) state_q <= PAY_HI;
                    end
                end
                GAP: begin
                    gap_q <= gap_q + 16'd1;
                end
                default: state_q <= IDLE;
            endcase

            if (pkt_end) begin
                if (line_q == LINE_LAST) begin
                    frame_done_q <= 1'b1;
                    frame_id_q   <= frame_id_q + 8'd1;
                    state_q      <= IDLE;
                end else begin
                    line_q    <= line_q + 16'd1;
                    word_q    <= '0;
                    hdr_q     <= '0;
                    pkt_req_q <= 1'b1;
                    state_q   <= REQ;
                end
            end
        end
    end

    assign bus.src_ready  = src_take;
    assign bus.pkt_req    = pkt_req_q;
    assign bus.pkt_len    = 16'(2 * PKT_WORDS + 4);
    assign bus.tx_valid   = tx_valid_q;
    assign bus.tx_data    = tx_data_q;
    assign bus.tx_last    = tx_last_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;
    assign bus.frame_id   = frame_id_q;
endmodule

// File: tb/tb_udp_photo_tx_packetizer.sv
// Self-checking bench: frame scenarios from a table, randomized handshakes,
// and a byte-stream reference model built from the packet format rules.
module tb_udp_photo_tx_packetizer;
    localparam int PW = 4;
    localparam int PN = 2;
    localparam int G  = 3;
    localparam int BUDGET = 2000;

    typedef struct {
        int         ready_pct;
        int         ack_delay;
        int         ack_noise;
        int         starve_at;
        int         starve_len;
        int         extra_start;
        logic [7:0] exp_fid;
    } vec_t;

    logic sys_clk = 1'b0;
    logic rst_n   = 1'b0;
    udp_photo_tx_packetizer_if bus ();

    udp_photo_tx_packetizer #(
        .PKT_WORDS (PW),
        .PKT_NUM   (PN),
        .GAP_CYCLES(G),
        .HDR_MAGIC (8'hA5)
    ) dut (
        .sys_clk(sys_clk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int         n_vec = 0;
    int         n_err = 0;
    int         src_idx = 0;
    logic [7:0] mfid = 8'd0;
    logic [8:0] got_q[$];
    vec_t       vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    function automatic logic [15:0] word_of(input int k);
        logic [7:0] hi;
        logic [7:0] lo;
        hi = 8'(17 * (2 * k + 1));
        lo = 8'(17 * (2 * k + 2));
        return {hi, lo};
    endfunction

    function automatic logic [31:0] outs_now();
        return 32'({bus.src_ready, bus.pkt_req, bus.tx_valid, bus.tx_data, bus.tx_last,
                    bus.busy, bus.frame_done, bus.frame_id});
    endfunction

    // Monitor on the falling edge: accepted bytes, stall stability, gap length, source use.
    initial begin
        logic       stall;
        logic [7:0] hold_data;
        logic       hold_last;
        int         gap_tb;
        stall  = 1'b0;
        gap_tb = -1;
        hold_data = '0;
        hold_last = 1'b0;
        forever begin
            @(negedge sys_clk);
            if (!rst_n) begin
                stall  = 1'b0;
                gap_tb = -1;
            end else begin
                if (stall)
                    check("stall_hold", 32'({bus.tx_valid, bus.tx_last, bus.tx_data}),
                          32'({1'b1, hold_last, hold_data}));
                stall     = bus.tx_valid && !bus.tx_ready;
                hold_data = bus.tx_data;
                hold_last = bus.tx_last;
                if (!bus.src_valid) check("src_ready_without_valid", 32'(bus.src_ready), 32'd0);
                if (gap_tb >= 0) begin
                    gap_tb++;
                    if (bus.pkt_req || bus.frame_done) begin
                        check("gap_len", 32'(gap_tb), 32'(G + 1));
                        gap_tb = -1;
                    end
                end
                if (bus.tx_valid && bus.tx_ready) begin
                    got_q.push_back({bus.tx_last, bus.tx_data});
                    if (bus.tx_last) gap_tb = 0;
                end
                if (bus.src_valid && bus.src_ready) src_idx++;
            end
        end
    end

    task automatic run_frame(input vec_t v);
        logic [8:0] exp_q[$];
        logic [15:0] w;
        int base;
        int cyc;
        int req_cyc;
        int starve_left;
        bit done;
        base = src_idx;
        exp_q = {};
        for (int l = 0; l < PN; l++) begin
            exp_q.push_back({1'b0, 8'hA5});
            exp_q.push_back({1'b0, mfid});
            exp_q.push_back({1'b0, 8'(l >> 8)});
            exp_q.push_back({1'b0, 8'(l)});
            for (int k = 0; k < PW; k++) begin
                w = word_of(base + l * PW + k);
                exp_q.push_back({1'b0, w[15:8]});
                exp_q.push_back({k == PW - 1, w[7:0]});
            end
        end
        got_q.delete();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        cyc = 0;
        req_cyc = 0;
        starve_left = v.starve_len;
        done = 1'b0;
        while (!done && cyc < BUDGET) begin
            bus.start    = (v.extra_start != 0) && (cyc == 5);
            bus.tx_ready = ($urandom_range(99) < v.ready_pct);
            if (v.starve_at >= 0 && (src_idx - base) >= v.starve_at && starve_left > 0) begin
                bus.src_valid = 1'b0;
                starve_left--;
            end else begin
                bus.src_valid = 1'b1;
            end
            bus.src_data = bus.src_valid ? word_of(src_idx) : 16'($urandom);
            if (bus.pkt_req) begin
                req_cyc++;
                bus.pkt_ack = (req_cyc > v.ack_delay);
            end else begin
                req_cyc = 0;
                bus.pkt_ack = (v.ack_noise != 0) && ($urandom_range(1) == 1);
            end
            #1;
            if (cyc == 0) check("busy_after_start", 32'(bus.busy), 32'd1);
            if (v.ack_delay > 1 && bus.pkt_req && !bus.pkt_ack)
                check("req_hold", 32'({bus.pkt_req, bus.tx_valid, bus.src_ready}), 32'b100);
            if (bus.frame_done) begin
                check("busy_at_done", 32'(bus.busy), 32'd1);
                bus.start = (v.extra_start != 0);
                done = 1'b1;
            end
            tick();
            cyc++;
        end
        bus.start = 1'b0;
        bus.tx_ready = 1'b1;
        bus.src_valid = 1'b0;
        bus.pkt_ack = 1'b0;
        if (!done) check("frame_timeout", 32'd0, 32'd1);
        check("after_done", 32'({bus.busy, bus.frame_done}), 32'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("idle_after_frame", 32'({bus.pkt_req, bus.busy}), 32'd0);
        end
        check("byte_count", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check("byte", 32'(got_q[i]), 32'(exp_q[i]));
        check("frame_id", 32'(bus.frame_id), 32'(v.exp_fid));
        mfid = mfid + 8'd1;
    endtask

    initial begin
        vec_t v;
        vecs[0] = '{ready_pct: 100, ack_delay: 1,  ack_noise: 0, starve_at: -1, starve_len: 0,  extra_start: 0, exp_fid: 8'd1};
        vecs[1] = '{ready_pct: 30,  ack_delay: 1,  ack_noise: 1, starve_at: -1, starve_len: 0,  extra_start: 0, exp_fid: 8'd2};
        vecs[2] = '{ready_pct: 100, ack_delay: 1,  ack_noise: 0, starve_at: 6,  starve_len: 10, extra_start: 0, exp_fid: 8'd3};
        vecs[3] = '{ready_pct: 100, ack_delay: 50, ack_noise: 0, starve_at: -1, starve_len: 0,  extra_start: 0, exp_fid: 8'd4};
        vecs[4] = '{ready_pct: 60,  ack_delay: 3,  ack_noise: 1, starve_at: 2,  starve_len: 10, extra_start: 1, exp_fid: 8'd5};

        bus.start = 1'b0;
        bus.src_valid = 1'b0;
        bus.src_data = '0;
        bus.pkt_ack = 1'b0;
        bus.tx_ready = 1'b0;
        tick();
        check("reset_outputs", outs_now(), 32'd0);
        check("pkt_len", 32'(bus.pkt_len), 32'(2 * PW + 4));
        rst_n = 1'b1;
        tick();
        tick();
        check("idle_outputs", outs_now(), 32'd0);

        foreach (vecs[i]) run_frame(vecs[i]);

        // Reset while packet 1 is mid-payload, then a fresh frame restarts at line 0, frame 0.
        got_q.delete();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.tx_ready = 1'b1;
        for (int c = 0; c < 500 && got_q.size() < 4 + 2 * PW + 4 + 2; c++) begin
            bus.src_valid = 1'b1;
            bus.src_data = word_of(src_idx);
            bus.pkt_ack = bus.pkt_req;
            tick();
        end
        check("reached_pkt1_payload", 32'(got_q.size() >= 4 + 2 * PW + 4 + 2), 32'd1);
        rst_n = 1'b0;
        bus.src_valid = 1'b0;
        bus.pkt_ack = 1'b0;
        #1;
        check("reset_abort_now", outs_now(), 32'd0);
        tick();
        check("reset_abort_next", outs_now(), 32'd0);
        rst_n = 1'b1;
        mfid = 8'd0;
        tick();
        v = '{ready_pct: 100, ack_delay: 1, ack_noise: 0, starve_at: -1, starve_len: 0, extra_start: 0, exp_fid: 8'd1};
        run_frame(v);

        // Run frames until frame_id wraps past 255.
        for (int f = 0; f < 255; f++) begin
            v = '{ready_pct: 100, ack_delay: 1, ack_noise: 0, starve_at: -1, starve_len: 0,
                  extra_start: 0, exp_fid: mfid + 8'd1};
            run_frame(v);
        end
        check("frame_id_wrap", 32'(bus.frame_id), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog expired");
    end
endmodule
